bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/bus_pkg.sv | 21 ++
 rtl/bus_fifo.sv | 59 +++++
 rtl/bus_responder.sv | 147 ++++++++++++++
 tb/tb_bus_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus-cycle state encoding and address map for the CPU bus responder.
package bus_pkg;

  typedef enum logic [1:0] {PH1, RD, WR, IGN} bus_state_e;

  localparam logic [15:0] MB_DATA_ADDR = 16'h4020;
  localparam logic [15:0] MB_STAT_ADDR = 16'h4021;
  localparam logic [15:0] MIRROR_MASK  = 16'hE000;

  function automatic logic is_ram(input logic [15:0] addr);
    return (addr & MIRROR_MASK) == '0;
  endfunction

  function automatic bus_state_e decode(input logic [15:0] addr, input logic rd);
    if (is_ram(addr))                 return rd ? RD : WR;
    if (addr == MB_DATA_ADDR && !rd)  return WR;
    if (addr == MB_STAT_ADDR && rd)   return RD;
    return IGN;
  endfunction

endpackage

// File: rtl/bus_fifo.sv
// Mailbox FIFO: pointers carry one extra wrap bit; head entry is presented from a register.
module bus_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic         o_full,
  output logic         o_empty,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [AW:0]  r_wr, r_rd, w_wr_nxt, w_rd_nxt;
  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_head, w_head_nxt;
  logic         w_push, w_pop, w_empty_nxt;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_valid = ~o_empty;
  assign o_data  = r_head;
  assign w_pop   = i_pop && !o_empty;
  // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
  assign w_push  = i_push && (!o_full || w_pop);

  always_comb begin
    w_wr_nxt    = w_push ? r_wr + ONE : r_wr;
    w_rd_nxt    = w_pop  ? r_rd + ONE : r_rd;
    w_empty_nxt = (w_wr_nxt == w_rd_nxt);
    w_head_nxt  = '0;
    if (!w_empty_nxt) begin
      if (w_push && (r_wr[AW-1:0] == w_rd_nxt[AW-1:0])) w_head_nxt = i_din;
      else                                             w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= '0;
    end else begin
      r_wr   <= w_wr_nxt;
      r_rd   <= w_rd_nxt;
      r_head <= w_head_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/bus_responder.sv
// CPU bus responder: mirrored work RAM with optional read wait states, plus a mailbox FIFO
// with sticky overflow status. Everything runs on ph0; the CPU phase is recovered from ph2 edges.
module bus_responder
  import bus_pkg::*;
#(
  parameter int unsigned RAM_AW      = 11,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        ph0,
  input  logic        reset,
  input  logic        ph2,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        rdy,
  output logic        mb_valid,
  output logic [7:0]  mb_data,
  input  logic        mb_ready
);
  localparam logic [2:0] WS = 3'(WAIT_STATES);

  bus_state_e  r_state, w_state_nxt;
  logic        r_ph2_q, w_rise, w_fall, w_start;
  logic [15:0] r_addr;
  logic        r_rw;
  logic [7:0]  r_din_q, r_dout;
  logic        r_oe, r_rdy, r_ovf, r_stall, r_wait_done;
  logic [2:0]  r_wait_cnt;
  logic [7:0]  r_ram [2**RAM_AW];

  logic        w_in_ram, w_is_stat, w_is_mb, w_commit, w_ram_we, w_push_req;
  logic        w_stat_done, w_rd_drive, w_ram_rd_start;
  logic        w_full, w_empty, w_pop;
  logic [7:0]  w_status;

  assign w_rise  = ph2 & ~r_ph2_q;
  assign w_fall  = ~ph2 & r_ph2_q;
  assign w_start = w_rise && (r_state == PH1);

  always_ff @(posedge ph0 or posedge reset) begin
    if (reset) r_state <= PH1;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_fall)       w_state_nxt = PH1;
    else if (w_start) w_state_nxt = decode(a, rw);
  end

  always_comb begin
    w_in_ram       = is_ram(r_addr);
    w_is_stat      = (r_addr == MB_STAT_ADDR);
    w_is_mb        = (r_addr == MB_DATA_ADDR);
    w_commit       = w_fall && (r_state == WR) && !r_rw;
    w_ram_we       = w_commit && w_in_ram;
    w_push_req     = w_commit && w_is_mb;
    w_stat_done    = w_fall && (r_state == RD) && w_is_stat;
    w_rd_drive     = (r_state == RD) && !w_fall && !r_stall;
    w_ram_rd_start = w_start && (w_state_nxt == RD) && is_ram(a);
  end

  assign w_status = {5'b0, r_ovf, w_empty, w_full};
  assign w_pop    = mb_ready & mb_valid;

  always_ff @(posedge ph0 or posedge reset) begin
    if (reset) begin
      r_ph2_q     <= 1'b0;
      r_din_q     <= '0;
      r_addr      <= '0;
      r_rw        <= 1'b1;
      r_dout      <= '0;
      r_oe        <= 1'b0;
      r_rdy       <= 1'b1;
      r_ovf       <= 1'b0;
      r_stall     <= 1'b0;
      r_wait_done <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_ph2_q <= ph2;
      r_din_q <= d_in;
      if (w_start) begin
        r_addr <= a;
        r_rw   <= rw;
      end

      if (w_rd_drive) begin
        r_oe <= 1'b1;
        if (!r_oe) r_dout <= w_is_stat ? w_status : r_ram[r_addr[RAM_AW-1:0]];
      end else begin
        r_oe <= 1'b0;
      end

      // The first RAM read arms the counter; CPU repeats of that read keep stalling until it
      // drains, and the read after the drain is let through once.
      if (w_ram_rd_start) begin
        if (r_wait_done || WAIT_STATES == 0) begin
          r_stall     <= 1'b0;
          r_wait_done <= 1'b0;
        end else begin
          r_stall <= 1'b1;
          if (r_wait_cnt == '0) r_wait_cnt <= WS;
        end
      end else if (w_start) begin
        r_stall <= 1'b0;
      end
      if ((r_state == RD) && r_stall && !w_fall) r_rdy <= 1'b0;
      if (w_fall && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
        if (r_wait_cnt == 3'd1) begin
          r_wait_done <= 1'b1;
          r_rdy       <= 1'b1;
        end
      end

      if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
      else if (w_stat_done)               r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge ph0) begin
    if (w_ram_we) r_ram[r_addr[RAM_AW-1:0]] <= r_din_q;
  end

  bus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .i_clk   (ph0),
    .i_rst   (reset),
    .i_push  (w_push_req),
    .i_din   (r_din_q),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_valid (mb_valid),
    .o_data  (mb_data)
  );

  assign d_out = r_dout;
  assign d_oe  = r_oe;
  assign rdy   = r_rdy;

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: a zero-wait instance and a two-wait-state instance share one CPU bus.
module tb_bus_responder;
  localparam int FD = 4;

  logic        ph0 = 1'b0, reset = 1'b1, ph2 = 1'b0, rw = 1'b1, mb_ready = 1'b0;
  logic [15:0] a = '0;
  logic [7:0]  d_in = '0;
  logic [7:0]  d_out0, d_out1, mb_data0, mb_data1;
  logic        d_oe0, d_oe1, rdy0, rdy1, mb_valid0, mb_valid1;

  bus_responder u_dut0 (
    .ph0(ph0), .reset(reset), .ph2(ph2), .a(a), .rw(rw), .d_in(d_in),
    .d_out(d_out0), .d_oe(d_oe0), .rdy(rdy0),
    .mb_valid(mb_valid0), .mb_data(mb_data0), .mb_ready(mb_ready)
  );

  bus_responder #(.WAIT_STATES(2)) u_dut1 (
    .ph0(ph0), .reset(reset), .ph2(ph2), .a(a), .rw(rw), .d_in(d_in),
    .d_out(d_out1), .d_oe(d_oe1), .rdy(rdy1),
    .mb_valid(mb_valid1), .mb_data(mb_data1), .mb_ready(mb_ready)
  );

  always #5 ph0 = ~ph0;

  int n_chk = 0, n_err = 0;

  // Reference model of the memory map.
  logic [7:0] ram_m [2048];
  logic [7:0] fifo_q [$];
  logic       ovf_m = 1'b0;
  logic       exp_oe;
  logic [7:0] exp_dout;

  // Observations from the last CPU cycle, bit 0 = zero-wait DUT, bit 1 = wait-state DUT.
  logic [1:0] o_oe_rise, o_oe_e1, o_oe_hold, o_oe_any, o_oe_fall, o_rdy_all, o_rdy_e1, o_rdy_fall;
  logic [7:0] o_dout0, o_dout1;

  task automatic cpu_cycle(input logic [15:0] addr, input logic rd, input logic [7:0] wdata,
                           input logic pop_at_fall);
    @(negedge ph0); ph2 = 1'b0; a = addr; rw = rd; d_in = wdata;
    repeat (2) @(negedge ph0);
    ph2 = 1'b1;
    @(posedge ph0); #1;
    o_oe_rise = {d_oe1, d_oe0}; o_oe_any = o_oe_rise; o_rdy_all = {rdy1, rdy0};
    @(posedge ph0); #1;
    o_oe_e1 = {d_oe1, d_oe0}; o_rdy_e1 = {rdy1, rdy0}; o_dout0 = d_out0; o_dout1 = d_out1;
    o_oe_hold = o_oe_e1; o_oe_any |= o_oe_e1; o_rdy_all &= o_rdy_e1;
    repeat (2) begin
      @(posedge ph0); #1;
      o_oe_hold &= {d_oe1, d_oe0}; o_oe_any |= {d_oe1, d_oe0}; o_rdy_all &= {rdy1, rdy0};
    end
    @(negedge ph0); ph2 = 1'b0; mb_ready = pop_at_fall;
    @(posedge ph0); #1;
    mb_ready = 1'b0;
    o_oe_fall = {d_oe1, d_oe0}; o_rdy_fall = {rdy1, rdy0}; o_oe_any |= o_oe_fall;
  endtask

  task automatic bus_op(input logic [15:0] addr, input logic rd, input logic [7:0] wdata,
                        input logic pop_at_fall);
    int idx;
    idx = int'(addr) % 2048;
    exp_oe = 1'b0; exp_dout = 'x;
    if (addr < 16'h2000 && rd) begin
      exp_oe = 1'b1; exp_dout = ram_m[idx];
    end else if (addr == 16'h4021 && rd) begin
      exp_oe = 1'b1;
      exp_dout = {5'b0, ovf_m, fifo_q.size() == 0, fifo_q.size() == FD};
    end
    cpu_cycle(addr, rd, wdata, pop_at_fall);
    if (pop_at_fall && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (!rd && addr < 16'h2000) ram_m[idx] = wdata;
    if (!rd && addr == 16'h4020) begin
      if (fifo_q.size() < FD) fifo_q.push_back(wdata);
      else                    ovf_m = 1'b1;
    end
    if (rd && addr == 16'h4021) ovf_m = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge ph0); reset = 1'b1; ph2 = 1'b0; mb_ready = 1'b0;
    repeat (2) @(negedge ph0);
    reset = 1'b0;
    fifo_q.delete(); ovf_m = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge ph0);
    n_chk++; if (d_oe0 !== 1'b0) begin n_err++; $display("FAIL rst_doe: got %b expected 0", d_oe0); end
    n_chk++; if (d_out0 !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h expected 00", d_out0); end
    n_chk++; if ({rdy1, rdy0} !== 2'b11) begin n_err++; $display("FAIL rst_rdy: got %b expected 11", {rdy1, rdy0}); end
    n_chk++; if ({mb_valid1, mb_valid0} !== 2'b00) begin n_err++; $display("FAIL rst_mbvalid: got %b expected 00", {mb_valid1, mb_valid0}); end
    n_chk++; if (mb_data0 !== 8'h00) begin n_err++; $display("FAIL rst_mbdata: got %h expected 00", mb_data0); end
    bus_op(16'h4021, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_dout0 !== 8'h02 || o_oe_e1[0] !== 1'b1) begin n_err++; $display("FAIL rst_status: got %h oe %b expected 02 oe 1", o_dout0, o_oe_e1[0]); end
  endtask

  task automatic test_ram_mirror();
    bus_op(16'h0123, 1'b0, 8'h55, 1'b0);
    n_chk++; if (o_oe_any[0] !== 1'b0) begin n_err++; $display("FAIL wr_no_oe: got %b expected 0", o_oe_any[0]); end
    bus_op(16'h0923, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_oe_rise[0] !== 1'b0) begin n_err++; $display("FAIL rd_oe_at_rise: got %b expected 0", o_oe_rise[0]); end
    n_chk++; if (o_oe_e1[0] !== 1'b1) begin n_err++; $display("FAIL rd_oe_after_rise: got %b expected 1", o_oe_e1[0]); end
    n_chk++; if (o_dout0 !== 8'h55) begin n_err++; $display("FAIL rd_mirror_data: got %h expected 55", o_dout0); end
    n_chk++; if (o_oe_hold[0] !== 1'b1) begin n_err++; $display("FAIL rd_oe_hold: got %b expected 1", o_oe_hold[0]); end
    n_chk++; if (o_oe_fall[0] !== 1'b0) begin n_err++; $display("FAIL rd_oe_at_fall: got %b expected 0", o_oe_fall[0]); end
    n_chk++; if (o_rdy_all[0] !== 1'b1) begin n_err++; $display("FAIL rd_rdy: got %b expected 1", o_rdy_all[0]); end
  endtask

  task automatic test_unmapped();
    logic [15:0] addrs [5] = '{16'h5000, 16'h2000, 16'h4020, 16'hFFFF, 16'h3FFF};
    foreach (addrs[i]) begin
      bus_op(addrs[i], 1'b1, 8'h00, 1'b0);
      n_chk++; if (o_oe_any[0] !== 1'b0) begin n_err++; $display("FAIL unmapped_oe %h: got %b expected 0", addrs[i], o_oe_any[0]); end
      n_chk++; if (o_rdy_all[0] !== 1'b1 || o_rdy_fall[0] !== 1'b1) begin n_err++; $display("FAIL unmapped_rdy %h: got %b expected 1", addrs[i], o_rdy_all[0]); end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    bus_op(16'h0010, 1'b0, 8'hAA, 1'b0);
    bus_op(16'h0010, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_rdy_e1[1] !== 1'b0) begin n_err++; $display("FAIL ws_c1_rdy: got %b expected 0", o_rdy_e1[1]); end
    n_chk++; if (o_oe_any[1] !== 1'b0) begin n_err++; $display("FAIL ws_c1_oe: got %b expected 0", o_oe_any[1]); end
    n_chk++; if (o_rdy_fall[1] !== 1'b0) begin n_err++; $display("FAIL ws_c1_rdy_fall: got %b expected 0", o_rdy_fall[1]); end
    n_chk++; if (o_dout0 !== 8'hAA || o_rdy_all[0] !== 1'b1) begin n_err++; $display("FAIL ws0_c1: got %h rdy %b expected aa rdy 1", o_dout0, o_rdy_all[0]); end
    bus_op(16'h0010, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_rdy_all[1] !== 1'b0) begin n_err++; $display("FAIL ws_c2_rdy: got %b expected 0", o_rdy_all[1]); end
    n_chk++; if (o_oe_any[1] !== 1'b0) begin n_err++; $display("FAIL ws_c2_oe: got %b expected 0", o_oe_any[1]); end
    n_chk++; if (o_rdy_fall[1] !== 1'b1) begin n_err++; $display("FAIL ws_c2_rdy_release: got %b expected 1", o_rdy_fall[1]); end
    bus_op(16'h0010, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_oe_e1[1] !== 1'b1 || o_dout1 !== 8'hAA) begin n_err++; $display("FAIL ws_c3_data: got %h oe %b expected aa oe 1", o_dout1, o_oe_e1[1]); end
    n_chk++; if (o_rdy_all[1] !== 1'b1) begin n_err++; $display("FAIL ws_c3_rdy: got %b expected 1", o_rdy_all[1]); end
  endtask

  task automatic test_mailbox();
    do_reset();
    for (int i = 1; i <= 5; i++) bus_op(16'h4020, 1'b0, 8'(i), 1'b0);
    bus_op(16'h4021, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_dout0 !== 8'h05) begin n_err++; $display("FAIL mb_status_ovf: got %h expected 05", o_dout0); end
    bus_op(16'h4021, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_dout0 !== 8'h01) begin n_err++; $display("FAIL mb_status_clr: got %h expected 01", o_dout0); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge ph0);
      n_chk++; if (mb_valid0 !== 1'b1 || mb_data0 !== 8'(i)) begin n_err++; $display("FAIL mb_pop%0d: got v%b %h expected v1 %h", i, mb_valid0, mb_data0, 8'(i)); end
      mb_ready = 1'b1;
      void'(fifo_q.pop_front());
    end
    @(negedge ph0); mb_ready = 1'b0;
    n_chk++; if (mb_valid0 !== 1'b0) begin n_err++; $display("FAIL mb_drained: got %b expected 0", mb_valid0); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] b [4];
    do_reset();
    foreach (b[i]) begin b[i] = 8'($urandom); bus_op(16'h4020, 1'b0, b[i], 1'b0); end
    bus_op(16'h4021, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_dout0 !== 8'h01) begin n_err++; $display("FAIL pp_full_status: got %h expected 01", o_dout0); end
    bus_op(16'h4020, 1'b0, 8'h77, 1'b1);
    bus_op(16'h4021, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_dout0 !== 8'h01 || o_dout0 !== exp_dout) begin n_err++; $display("FAIL pp_no_ovf: got %h expected 01", o_dout0); end
    for (int i = 1; i <= 4; i++) begin
      @(negedge ph0);
      n_chk++; if (mb_data0 !== ((i == 4) ? 8'h77 : b[i])) begin n_err++; $display("FAIL pp_order%0d: got %h expected %h", i, mb_data0, (i == 4) ? 8'h77 : b[i]); end
      mb_ready = 1'b1;
    end
    @(negedge ph0); mb_ready = 1'b0; fifo_q.delete();
  endtask

  task automatic test_random();
    int written [$];
    logic [15:0] addr;
    logic rd, pop;
    logic [7:0] wd;
    int op, idx;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 4); pop = 1'($urandom_range(0, 1)); wd = 8'($urandom); rd = 1'b1;
      if (op == 1 && written.size() == 0) op = 0;
      case (op)
        0: begin addr = 16'($urandom_range(0, 16'h1FFF)); rd = 1'b0; written.push_back(int'(addr) % 2048); end
        1: begin idx = written[$urandom_range(0, written.size() - 1)]; addr = 16'(idx + 2048 * $urandom_range(0, 3)); end
        2: begin addr = 16'h4020; rd = 1'b0; end
        3: addr = 16'h4021;
        default: begin addr = 16'($urandom_range(16'h8000, 16'hFFFF)); rd = 1'($urandom_range(0, 1)); end
      endcase
      bus_op(addr, rd, wd, pop);
      n_chk++; if (o_oe_e1[0] !== exp_oe || (exp_oe && o_dout0 !== exp_dout)) begin n_err++; $display("FAIL rand%0d %h: got oe%b %h expected oe%b %h", n, addr, o_oe_e1[0], o_dout0, exp_oe, exp_dout); end
      if (!exp_oe) begin
        n_chk++; if (o_oe_any[0] !== 1'b0) begin n_err++; $display("FAIL rand%0d_oe %h: got %b expected 0", n, addr, o_oe_any[0]); end
      end
      n_chk++; if (mb_valid0 !== (fifo_q.size() != 0) || (fifo_q.size() != 0 && mb_data0 !== fifo_q[0])) begin n_err++; $display("FAIL rand%0d_mb: got v%b %h expected v%b", n, mb_valid0, mb_data0, fifo_q.size() != 0); end
    end
  endtask

  task automatic test_reset_mid_cycle();
    do_reset();
    bus_op(16'h0123, 1'b0, 8'h3C, 1'b0);
    bus_op(16'h4020, 1'b0, 8'h9E, 1'b0);
    @(negedge ph0); a = 16'h0123; rw = 1'b1;
    repeat (2) @(negedge ph0);
    ph2 = 1'b1;
    repeat (2) @(posedge ph0);
    #1;
    n_chk++; if (d_oe0 !== 1'b1 || mb_valid0 !== 1'b1) begin n_err++; $display("FAIL mid_pre: got oe%b v%b expected oe1 v1", d_oe0, mb_valid0); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if (d_oe0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_oe: got %b expected 0", d_oe0); end
    n_chk++; if ({rdy1, rdy0} !== 2'b11) begin n_err++; $display("FAIL mid_rst_rdy: got %b expected 11", {rdy1, rdy0}); end
    n_chk++; if (mb_valid0 !== 1'b0) begin n_err++; $display("FAIL mid_rst_mbvalid: got %b expected 0", mb_valid0); end
    @(negedge ph0); ph2 = 1'b0;
    @(negedge ph0); reset = 1'b0;
    fifo_q.delete(); ovf_m = 1'b0;
    @(negedge ph0); a = 16'h0123; rw = 1'b0; d_in = 8'hC3;
    repeat (2) @(negedge ph0);
    ph2 = 1'b1;
    repeat (2) @(posedge ph0);
    #3 reset = 1'b1;
    @(negedge ph0); ph2 = 1'b0;
    @(negedge ph0); reset = 1'b0;
    bus_op(16'h0123, 1'b1, 8'h00, 1'b0);
    n_chk++; if (o_dout0 !== 8'h3C) begin n_err++; $display("FAIL mid_wr_discard: got %h expected 3c", o_dout0); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ram_mirror();
    test_unmapped();
    test_wait_states();
    test_mailbox();
    test_push_pop_full();
    test_random();
    test_reset_mid_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
